dff_reg_write_arbiter: RTL and testbench

//   Round-robin arbiter and write sequencer for one shared WIDTH-bit storage register built from our

---
 rtl/dff_reg_write_arbiter.sv | 126 ++++++++++++
 tb/tb_dff_reg_write_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_reg_write_arbiter.sv
// Round-robin arbiter/write sequencer for one shared WIDTH-bit register (IDLE -> GRANT -> WRITE).
// Optional feature macro ARB_LOCK_EN: adds the lock port and up to LOCK_MAX back-to-back writes.
module dff_reg_write_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic                  Clk,
  input  logic                  RST_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]       lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      Q,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

  state_t                      state;
  logic [IW-1:0]               rr_ptr, idx, win, nxt_ptr;
  logic [IW:0]                 j;
  logic                        found;
  logic [NREQ-1:0]             win_oh;
  logic [NREQ-1:0][WIDTH-1:0]  slices;

`ifdef ARB_LOCK_EN
  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1;
  logic [CW-1:0] lock_cnt;
  logic          hold;
  assign hold = lock[idx] && req[idx] && (lock_cnt < CW'(LOCK_MAX - 1));
`endif

  assign slices  = wdata;
  assign win_oh  = NREQ'(1) << win;
  assign nxt_ptr = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;

  // First set request at or above rr_ptr, wrapping past NREQ-1.
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = {1'b0, rr_ptr} + (IW+1)'(k);
      if (j >= (IW+1)'(NREQ)) j = j - (IW+1)'(NREQ);
      if (!found && req[j[IW-1:0]]) begin
        found = 1'b1;
        win   = j[IW-1:0];
      end
    end
  end

  always_ff @(posedge Clk or negedge RST_n) begin
    if (!RST_n) begin
      state  <= IDLE;
      gnt    <= '0;
      ack    <= '0;
      Q      <= '0;
      busy   <= 1'b0;
      rr_ptr <= '0;
      idx    <= '0;
`ifdef ARB_LOCK_EN
      lock_cnt <= '0;
`endif
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= win_oh;
            idx   <= win;
            busy  <= 1'b1;
            state <= GRANT;
          end else begin
            gnt <= '0;
          end
        end
        GRANT: begin
          if (req[idx]) begin
            Q     <= slices[idx];
            ack   <= gnt;
            state <= WRITE;
          end else begin
            // Requester withdrew: drop the grant, pointer stays so it keeps its turn.
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef ARB_LOCK_EN
            lock_cnt <= '0;
`endif
          end
        end
        WRITE: begin
`ifdef ARB_LOCK_EN
          if (hold) begin
            lock_cnt <= lock_cnt + 1'b1;
            state    <= GRANT;
          end else begin
            lock_cnt <= '0;
            gnt      <= '0;
            rr_ptr   <= nxt_ptr;
            busy     <= 1'b0;
            state    <= IDLE;
          end
`else
          gnt    <= '0;
          rr_ptr <= nxt_ptr;
          busy   <= 1'b0;
          state  <= IDLE;
`endif
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_reg_write_arbiter.sv
// Scoreboard bench for dff_reg_write_arbiter: expected acks/data queued at stimulus, checked on ack.
module tb_dff_reg_write_arbiter;
  localparam int NREQ = 4, WIDTH = 8, LOCK_MAX = 4;

  logic                  Clk = 1'b0;
  logic                  RST_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] wdata = '0;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]       lock = '0;
`endif
  logic [NREQ-1:0]       gnt, ack;
  logic [WIDTH-1:0]      Q;
  logic                  busy;

  typedef struct {logic [NREQ-1:0] a; logic [WIDTH-1:0] q;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, ack_cnt = 0;

  dff_reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)) dut (
    .Clk(Clk), .RST_n(RST_n), .req(req), .wdata(wdata),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .ack(ack), .Q(Q), .busy(busy));

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  always @(negedge Clk) begin
    if (RST_n) begin
      total++;
      if ($countones(gnt) > 1 || (ack & ~gnt) != '0) begin
        bad++;
        $display("FAIL onehot: gnt=%b ack=%b (gnt one-hot, ack within gnt)", gnt, ack);
      end
      if (ack !== '0) begin
        ack_cnt++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: ack=%b Q=%h, no write expected", ack, Q);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (ack !== e.a || Q !== e.q) begin
            bad++;
            $display("FAIL sb_write: ack=%b Q=%h, expected ack=%b Q=%h", ack, Q, e.a, e.q);
          end
        end
      end
    end
  end

  function automatic exp_t mk(input int i, input logic [WIDTH-1:0] d);
    exp_t e;
    e.a = NREQ'(1) << i;
    e.q = d;
    return e;
  endfunction

  task automatic do_reset();
    @(posedge Clk); #1;
    req = '0;
    RST_n = 1'b0;
    #2;
    RST_n = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    int target;
    logic [NREQ*WIDTH-1:0] w;
    RST_n = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    total++;
    if (gnt !== '0 || ack !== '0 || Q !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: gnt=%b ack=%b Q=%h busy=%b, expected all zero", gnt, ack, Q, busy);
    end
    @(posedge Clk); #1;
    RST_n = 1'b1;
    // load 5A, then re-request and reset while in GRANT
    w = '0; w[0 +: WIDTH] = 8'h5A; wdata = w;
    sb.push_back(mk(0, 8'h5A));
    target = ack_cnt + 1;
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      if (ack_cnt >= target) break;
      @(negedge Clk); #1;
    end
    total++;
    if (ack_cnt < target) begin bad++; $display("FAIL reset_prep_timeout: acks=%0d expected %0d", ack_cnt, target); end
    idle(3);
    w = '0; w[0 +: WIDTH] = 8'h99; wdata = w;
    req = 4'b0001;
    @(posedge Clk); #1;
    total++;
    if (gnt !== 4'b0001 || Q !== 8'h5A) begin
      bad++;
      $display("FAIL reset_pregrant: gnt=%b Q=%h, expected gnt=0001 Q=5a", gnt, Q);
    end
    #2;
    RST_n = 1'b0;
    #1;
    total++;
    if (gnt !== '0 || ack !== '0 || Q !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: gnt=%b ack=%b Q=%h busy=%b, expected all zero", gnt, ack, Q, busy);
    end
    req = '0;
    @(posedge Clk); #1;
    RST_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    logic [NREQ*WIDTH-1:0] w;
    w = '0; w[2*WIDTH +: WIDTH] = 8'hC3; wdata = w;
    sb.push_back(mk(2, 8'hC3));
    req = 4'b0100;
    @(posedge Clk); @(negedge Clk);
    total++;
    if (gnt !== 4'b0100 || ack !== '0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_grant: gnt=%b ack=%b busy=%b, expected 0100 0000 1", gnt, ack, busy);
    end
    @(negedge Clk);
    total++;
    if (ack !== 4'b0100 || Q !== 8'hC3) begin
      bad++;
      $display("FAIL single_write: ack=%b Q=%h, expected 0100 c3", ack, Q);
    end
    #1 req = '0;
    @(negedge Clk);
    total++;
    if (gnt !== '0 || ack !== '0 || busy !== 1'b0 || Q !== 8'hC3) begin
      bad++;
      $display("FAIL single_idle: gnt=%b ack=%b busy=%b Q=%h, expected 0 0 0 c3", gnt, ack, busy, Q);
    end
    @(posedge Clk); #1;
  endtask

  // rr_ptr is 3 after the single write to requester 2
  task automatic test_wrap();
    int target;
    logic [NREQ*WIDTH-1:0] w;
    w = '0; w[3*WIDTH +: WIDTH] = 8'h3C; w[0 +: WIDTH] = 8'hE0; wdata = w;
    sb.push_back(mk(3, 8'h3C));
    sb.push_back(mk(0, 8'hE0));
    target = ack_cnt + 2;
    req = 4'b1001;
    for (int c = 0; c < 30; c++) begin
      if (ack_cnt >= target) break;
      @(negedge Clk); #1;
    end
    req = '0;
    total++;
    if (ack_cnt < target) begin bad++; $display("FAIL wrap_timeout: acks=%0d expected %0d", ack_cnt, target); end
    idle(3);
  endtask

  task automatic test_round_robin();
    int target;
    logic [NREQ*WIDTH-1:0] w;
    do_reset();
    w = {8'h43, 8'h32, 8'h21, 8'h10}; wdata = w;
    for (int i = 0; i < 5; i++) sb.push_back(mk(i % NREQ, w[(i % NREQ)*WIDTH +: WIDTH]));
    target = ack_cnt + 5;
    req = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      if (ack_cnt >= target) break;
      @(negedge Clk); #1;
    end
    req = '0;
    total++;
    if (ack_cnt < target) begin bad++; $display("FAIL rr_timeout: acks=%0d expected %0d", ack_cnt, target); end
    idle(3);
  endtask

  task automatic test_abort();
    int target;
    logic [NREQ*WIDTH-1:0] w;
    do_reset();
    w = '0; w[0 +: WIDTH] = 8'hAA; wdata = w;
    sb.push_back(mk(0, 8'hAA));
    target = ack_cnt + 1;
    req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      if (ack_cnt >= target) break;
      @(negedge Clk); #1;
    end
    req = '0;
    total++;
    if (ack_cnt < target) begin bad++; $display("FAIL abort_prep_timeout: acks=%0d expected %0d", ack_cnt, target); end
    idle(3);
    w = '0; w[WIDTH +: WIDTH] = 8'h77; wdata = w;
    req = 4'b0010;
    @(posedge Clk); @(negedge Clk);
    total++;
    if (gnt !== 4'b0010) begin bad++; $display("FAIL abort_grant: gnt=%b expected 0010", gnt); end
    #1 req = '0;
    @(negedge Clk);
    total++;
    if (gnt !== '0 || ack !== '0 || busy !== 1'b0 || Q !== 8'hAA) begin
      bad++;
      $display("FAIL abort_state: gnt=%b ack=%b busy=%b Q=%h, expected 0 0 0 aa", gnt, ack, busy, Q);
    end
    #1;
    w = '0; w[0 +: WIDTH] = 8'hB0; w[WIDTH +: WIDTH] = 8'hB1; wdata = w;
    sb.push_back(mk(1, 8'hB1));
    sb.push_back(mk(0, 8'hB0));
    target = ack_cnt + 2;
    req = 4'b0011;
    for (int c = 0; c < 30; c++) begin
      if (ack_cnt >= target) break;
      @(negedge Clk); #1;
    end
    req = '0;
    total++;
    if (ack_cnt < target) begin bad++; $display("FAIL abort_retry_timeout: acks=%0d expected %0d", ack_cnt, target); end
    idle(3);
  endtask

  task automatic test_lock();
    int target;
    logic [NREQ*WIDTH-1:0] w;
    do_reset();
    w = '0; w[0 +: WIDTH] = 8'h05; w[WIDTH +: WIDTH] = 8'h06; wdata = w;
`ifdef ARB_LOCK_EN
    for (int i = 0; i < LOCK_MAX; i++) sb.push_back(mk(0, 8'h05));
    sb.push_back(mk(1, 8'h06));
    target = ack_cnt + LOCK_MAX + 1;
    lock = 4'b0001;
`else
    for (int i = 0; i < 5; i++) sb.push_back(mk(i % 2, (i % 2 == 0) ? 8'h05 : 8'h06));
    target = ack_cnt + 5;
`endif
    req = 4'b0011;
    for (int c = 0; c < 60; c++) begin
      if (ack_cnt >= target) break;
      @(negedge Clk); #1;
    end
    req = '0;
`ifdef ARB_LOCK_EN
    lock = '0;
`endif
    total++;
    if (ack_cnt < target) begin bad++; $display("FAIL lock_timeout: acks=%0d expected %0d", ack_cnt, target); end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_abort();
    test_lock();
    idle(4);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d pending writes, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
